// File: rtl/mmio_pkg.sv
// Register map constants and STATUS packing for the memory-mapped stream port.
package mmio_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CYCLE  = 2'd2;
  localparam logic [1:0] OFS_CTRL   = 2'd3;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_OVF_BIT   = 16;

  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_OVF_CLR_BIT = 1;

  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] s;
    s = '0;
    s[STATUS_EMPTY_BIT] = empty;
    s[STATUS_FULL_BIT]  = full;
    s[STATUS_OVF_BIT]   = ovf;
    s[STATUS_COUNT_LSB +: 8] = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; a push while full succeeds only alongside a pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mmio_stream_port.sv
// Data-memory-bus responder: stores to DATA feed a valid/ready stream via a FIFO;
// STATUS, CYCLE and CTRL registers give software visibility and control.
module mmio_stream_port
  import mmio_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'hF00,
  parameter int unsigned DEPTH     = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_mmio,
  output logic        hit,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [1:0]  offset;
  logic        wr_data, wr_cycle, wr_ctrl;
  logic        fifo_push, fifo_pop, fifo_flush;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic [31:0] fifo_head;
  logic [7:0]  count8;
  logic        ovf_q, ovf_d;
  logic [31:0] cycle_q, cycle_d;

  assign offset   = address_dmem[1:0];
  assign hit      = (address_dmem[11:2] == BASE_ADDR[11:2]);
  assign wr_data  = wren & hit & (offset == OFS_DATA);
  assign wr_cycle = wren & hit & (offset == OFS_CYCLE);
  assign wr_ctrl  = wren & hit & (offset == OFS_CTRL);

  assign fifo_push  = wr_data;
  assign fifo_pop   = out_valid & out_ready;
  assign fifo_flush = wr_ctrl & data[CTRL_FLUSH_BIT];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (data),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_head;
  assign count8    = 8'(fifo_count);

  always_comb begin
    ovf_d = ovf_q;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wr_ctrl && data[CTRL_OVF_CLR_BIT])   ovf_d = 1'b0;
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (wr_cycle) cycle_d = data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  always_comb begin
    q_mmio = '0;
    if (hit) begin
      case (offset)
        OFS_DATA:   q_mmio = fifo_head;
        OFS_STATUS: q_mmio = pack_status(fifo_empty, fifo_full, ovf_q, count8);
        OFS_CYCLE:  q_mmio = cycle_q;
        default:    q_mmio = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_stream_port.sv
// Bench for mmio_stream_port: directed register/stream scenarios, then random bus
// traffic, all compared each cycle against a queue-based model of the port.
module tb_mmio_stream_port;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] q_mmio;
  logic        hit;
  logic [31:0] out_data;
  logic        out_valid;

  mmio_stream_port #(
    .BASE_ADDR (12'hF00),
    .DEPTH     (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_mmio       (q_mmio),
    .hit          (hit),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic        m_ovf;
  logic [31:0] m_cyc;

  // Values sampled during the most recent step
  logic [31:0] cap_q, cap_data;
  logic        cap_hit, cap_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] r;
    int sz;
    sz = mq.size();
    r = 32'h0;
    if (a[11:2] == 10'h3C0) begin
      case (a[1:0])
        2'd0: r = (sz != 0) ? mq[0] : 32'h0;
        2'd1: begin
          r[0] = (sz == 0);
          r[1] = (sz == DEPTH);
          r[15:8] = 8'(sz);
          r[16] = m_ovf;
        end
        2'd2: r = m_cyc;
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  // One bus cycle: drive, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic we,
                      input logic rdy, input logic rst);
    int sz;
    logic pop, hitm;
    address_dmem = a;
    data = d;
    wren = we;
    out_ready = rdy;
    reset = rst;
    @(negedge clock);
    sz = mq.size();
    hitm = (a[11:2] == 10'h3C0);
    chk("hit", {31'b0, hit}, {31'b0, hitm});
    chk("q_mmio", q_mmio, model_read(a));
    chk("out_valid", {31'b0, out_valid}, {31'b0, (sz != 0)});
    chk("out_data", out_data, (sz != 0) ? mq[0] : 32'h0);
    cap_q = q_mmio;
    cap_hit = hit;
    cap_valid = out_valid;
    cap_data = out_data;
    @(posedge clock);
    pop = (sz != 0) && rdy;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cyc = 32'h0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (hitm && we) begin
        case (a[1:0])
          2'd0: begin
            if (sz == DEPTH && !pop) m_ovf = 1'b1;
            else mq.push_back(d);
          end
          2'd3: begin
            if (d[0]) mq.delete();
            if (d[1]) m_ovf = 1'b0;
          end
          default: ;
        endcase
      end
      m_cyc = (hitm && we && a[1:0] == 2'd2) ? d : m_cyc + 32'd1;
    end
    #1;
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    logic we, rdy, rst;

    // Initial reset: outputs are unknown until the first edge, so no checks here.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_cyc = 32'h0;

    // Reset state and free-running counter
    step(12'hF01, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_status", cap_q, 32'h0000_0001);
    chk("rst_valid", {31'b0, cap_valid}, 32'h0);
    chk("rst_data", cap_data, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step(12'hF02, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("cycle_count", cap_q, 32'(i));
    end

    // Three queued words, then drained in order
    step(12'hF00, 32'hA, 1'b1, 1'b0, 1'b0);
    step(12'hF00, 32'hB, 1'b1, 1'b0, 1'b0);
    step(12'hF00, 32'hC, 1'b1, 1'b0, 1'b0);
    step(12'hF01, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("status_3", cap_q, 32'h0000_0300);
    chk("head_a", cap_data, 32'hA);
    step(12'h000, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("drain_a", cap_data, 32'hA);
    step(12'h000, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("drain_b", cap_data, 32'hB);
    step(12'h000, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("drain_c", cap_data, 32'hC);
    step(12'h000, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("drained_valid", {31'b0, cap_valid}, 32'h0);

    // Overflow on DEPTH+1 pushes, then clear
    for (int i = 0; i <= DEPTH; i++) step(12'hF00, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
    step(12'hF01, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("status_ovf", cap_q, 32'h0001_1002);
    step(12'hF03, 32'h2, 1'b1, 1'b0, 1'b0);
    step(12'hF01, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("status_ovf_clr", cap_q, 32'h0000_1002);

    // Push and pop together while full
    step(12'hF00, 32'h55, 1'b1, 1'b1, 1'b0);
    step(12'hF01, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("status_full_pp", cap_q, 32'h0000_1002);
    for (int i = 0; i < DEPTH; i++) step(12'h000, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("last_is_55", cap_data, 32'h55);
    step(12'h000, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("empty_after_55", {31'b0, cap_valid}, 32'h0);

    // CYCLE load
    step(12'hF02, 32'h100, 1'b1, 1'b0, 1'b0);
    step(12'hF02, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("cycle_load", cap_q, 32'h100);
    step(12'hF02, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("cycle_load_inc", cap_q, 32'h101);

    // Flush with five queued
    for (int i = 0; i < 5; i++) step(12'hF00, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
    step(12'hF03, 32'h1, 1'b1, 1'b0, 1'b0);
    step(12'hF01, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_status", cap_q, 32'h0000_0001);
    chk("flush_valid", {31'b0, cap_valid}, 32'h0);

    // Out-of-window accesses leave the FIFO alone
    step(12'hF00, 32'h300, 1'b1, 1'b0, 1'b0);
    step(12'hF00, 32'h301, 1'b1, 1'b0, 1'b0);
    step(12'hEFF, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("miss_lo_hit", {31'b0, cap_hit}, 32'h0);
    chk("miss_lo_q", cap_q, 32'h0);
    step(12'hF04, 32'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("miss_hi_hit", {31'b0, cap_hit}, 32'h0);
    chk("miss_hi_q", cap_q, 32'h0);
    step(12'hF01, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("miss_status", cap_q, 32'h0000_0200);

    // Random traffic: a filling phase then a draining phase
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 4) == 0) ? 12'($urandom) : {10'h3C0, 2'($urandom)};
      we = 1'($urandom);
      d = $urandom;
      if (a[1:0] == 2'd3) begin
        d = 32'h0;
        d[0] = ($urandom_range(0, 7) == 0);
        d[1] = 1'($urandom);
      end
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      step(a, d, we, rdy, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_stream_port.md
# mmio_stream_port

Memory-mapped responder on the processor's data-memory bus: sits beside dmem, decodes a small address window, and turns processor `sw` stores into a 32-bit valid/ready output stream through an internal FIFO. Also exposes FIFO status, a sticky overflow flag and a free-running cycle counter for software. The top level muxes `q_mmio` onto `q_dmem` when `hit` is high and gates dmem `wren` with `!hit`.

## Interface
- `BASE_ADDR`, default 12'hF00: base word address of the 4-word window; must be 4-aligned.
- `DEPTH`, default 16: FIFO entries; power of 2, 2..256.
- `clock` in 1: processor clock; one bus access per cycle.
- `reset` in 1: synchronous, active-high.
- `address_dmem` in 12: word address from processor.
- `data` in 32: store data.
- `wren` in 1: store enable.
- `q_mmio` out 32: read data, combinational from `address_dmem`.
- `hit` out 1: combinational; 1 when `address_dmem[11:2] == BASE_ADDR[11:2]`.
- `out_data` out 32: FIFO head.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: downstream accepts head this cycle.

## Operation
- Register map (offset = `address_dmem[1:0]`):
  - 0 DATA: write pushes `data`; read returns head (peek, no pop; 0 when empty).
  - 1 STATUS, read-only: bit0 empty, bit1 full, bit16 overflow (sticky), bits[15:8] count; other bits 0. Writes ignored.
  - 2 CYCLE: read returns counter; write loads `data`.
  - 3 CTRL: write with `data[0]=1` flushes FIFO; write with `data[1]=1` clears overflow. Reads return 0.
- Reads have no side effects. `q_mmio` = 0 when `hit`=0.
- Push = `wren & hit & offset==0`. Pop = `out_valid & out_ready`.
- Push when full without a pop in the same cycle: data dropped, overflow set.
- Push and pop in the same cycle while full: both take effect; count unchanged; overflow not set.
- Push and pop in the same cycle while count in 1..DEPTH-1: count unchanged.
- Push while empty: `out_valid` rises the next cycle (no fall-through).
- Flush: pointers and count go to 0 at the edge. A concurrent pop is a completed transfer. Flush and an overflow-clear in the same write are both performed.
- CYCLE: increments by 1 every cycle and wraps at 2^32. A write at edge t makes it read `data` during cycle t+1, then `data+1`, and so on.
- Counter and pointer widths: log2(DEPTH) pointers with natural wrap; count is log2(DEPTH)+1 bits.

## Timing
- Reset values: FIFO empty, count 0, overflow 0, CYCLE 0, `out_valid` 0, `out_data` 0 (storage need not be cleared; the head mux reads 0 when empty).
- Write effects land at the rising edge where `wren` is sampled; a read in the next cycle observes them.
- Read path: `address_dmem` → `q_mmio`/`hit` is purely combinational, same cycle.
- Stream: `out_data` stays stable while `out_valid & !out_ready`. `out_valid` never drops without a pop, flush or reset.
- Reset mid-stream: a transfer in the reset cycle is not counted; contents are discarded.

## Structure
- Package `mmio_pkg`: offset constants (`OFS_DATA`=0, `OFS_STATUS`=1, `OFS_CYCLE`=2, `OFS_CTRL`=3), STATUS bit positions, CTRL bit positions.
- Sub-module `sync_fifo` (parameters DEPTH, WIDTH 32): push, pop, flush, full, empty, count and head outputs, with the same-cycle rules above.
- Top block contains the decode, STATUS/CTRL logic, the overflow flag, the CYCLE counter and the read mux.

## Test plan
- Reset, then read 0xF01 → 0x00000001; read 0xF02 in successive cycles → 1, 2, 3.
- Hold `out_ready`=0; store 0xA, 0xB, 0xC to 0xF00 → STATUS = 0x00000300, `out_data`=0xA. Raise `out_ready` → 0xA, 0xB, 0xC on consecutive cycles, then `out_valid`=0.
- Hold `out_ready`=0; perform DEPTH+1 pushes → STATUS = 0x00011002 (count 16, full, overflow); last value dropped. Write 0x2 to 0xF03 → bit16 clears; FIFO stays full.
- FIFO full and `out_ready`=1; push 0x55 in the same cycle → count stays 16, overflow stays 0, 0x55 emerges last.
- Write 0x100 to 0xF02, then read on the next two cycles → 0x100, 0x101. Write 0x1 to 0xF03 with 5 entries queued → next cycle STATUS = 0x00000001, `out_valid`=0.
- Access 0xEFF and 0xF04 → `hit`=0, `q_mmio`=0, FIFO unchanged.
